// File: rtl/mem_req_stage_if.sv
// Data-memory request/response bus between the MEM-stage issuer (master)
// and the data memory (slave).
interface mem_req_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_rmask;
    logic [3:0]      dmem_wmask;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_resp;

    modport master (
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_req_stage.sv
// MEM-stage data-memory request initiator: one outstanding dmem access, stalls until
// the response strobe. Define MISALIGN_TRAP_EN to flag misaligned h/w accesses instead of issuing them.
module mem_req_stage #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic              flush,
    mem_req_stage_if.master   bus,
    output logic              stall,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_rdata,
    output logic [1:0]        out_byte_off,
    output logic [2:0]        out_funct3,
    output logic              out_misalign
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]      state_reg, state_next;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic            is_store_reg;
    logic [1:0]      off_reg;
    logic [2:0]      funct3_reg;
    logic            squash_reg;

    logic            out_valid_reg;
    logic [XLEN-1:0] out_rdata_reg;
    logic [1:0]      out_byte_off_reg;
    logic [2:0]      out_funct3_reg;
    logic            out_misalign_reg;

    logic            is_mem;
    logic            misalign;
    logic            issue;
    logic [3:0]      size_mask;
    logic [XLEN-1:0] wdata_form;

    assign is_mem = in_is_load | in_is_store;

`ifdef MISALIGN_TRAP_EN
    assign misalign = is_mem &
                      (((in_funct3[1:0] == 2'b01) & in_addr[0]) |
                       ((in_funct3[1:0] == 2'b10) & (in_addr[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign issue = (state_reg == IDLE) & in_valid & is_mem & ~flush & ~misalign;

    // Halfword masks ignore off[0] and word masks ignore the offset entirely.
    always_comb begin
        size_mask = 4'b1111;
        case (in_funct3[1:0])
            2'b00:   size_mask = 4'b0001 << in_addr[1:0];
            2'b01:   size_mask = 4'b0011 << {in_addr[1], 1'b0};
            default: size_mask = 4'b1111;
        endcase
    end

    // Replicate the store operand so every enabled lane carries the right bytes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_form[gi*8 +: 8] =
            (in_funct3[1:0] == 2'b00) ? in_wdata[7:0] :
            (in_funct3[1:0] == 2'b01) ? in_wdata[(gi % 2)*8 +: 8] :
                                        in_wdata[gi*8 +: 8];
    end

    always_comb begin
        bus.dmem_addr  = (state_reg == WAIT) ? addr_reg  : {in_addr[XLEN-1:2], 2'b00};
        bus.dmem_wdata = (state_reg == WAIT) ? wdata_reg : wdata_form;
        bus.dmem_rmask = (issue & in_is_load)  ? size_mask : 4'b0000;
        bus.dmem_wmask = (issue & in_is_store) ? size_mask : 4'b0000;
        stall          = issue | ((state_reg == WAIT) & ~bus.dmem_resp);
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == IDLE) begin
            if (issue) state_next = WAIT;
        end else begin
            if (bus.dmem_resp) state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            is_store_reg     <= 1'b0;
            off_reg          <= 2'b00;
            funct3_reg       <= 3'b000;
            squash_reg       <= 1'b0;
            out_valid_reg    <= 1'b0;
            out_rdata_reg    <= '0;
            out_byte_off_reg <= 2'b00;
            out_funct3_reg   <= 3'b000;
            out_misalign_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (issue) begin
                    addr_reg     <= {in_addr[XLEN-1:2], 2'b00};
                    wdata_reg    <= wdata_form;
                    is_store_reg <= in_is_store;
                    off_reg      <= in_addr[1:0];
                    funct3_reg   <= in_funct3;
                    squash_reg   <= 1'b0;
                end else if (in_valid & ~flush) begin
                    // Non-memory op or trapped misaligned access: single-cycle pass-through.
                    out_valid_reg    <= 1'b1;
                    out_rdata_reg    <= '0;
                    out_byte_off_reg <= in_addr[1:0];
                    out_funct3_reg   <= in_funct3;
                    out_misalign_reg <= misalign;
                end
            end else begin
                if (flush) squash_reg <= 1'b1;
                if (bus.dmem_resp) begin
                    out_valid_reg    <= ~(squash_reg | flush);
                    out_rdata_reg    <= is_store_reg ? '0 : bus.dmem_rdata;
                    out_byte_off_reg <= off_reg;
                    out_funct3_reg   <= funct3_reg;
                    out_misalign_reg <= 1'b0;
                    squash_reg       <= 1'b0;
                end
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_rdata    = out_rdata_reg;
    assign out_byte_off = out_byte_off_reg;
    assign out_funct3   = out_funct3_reg;
    assign out_misalign = out_misalign_reg;
endmodule
